ped_walk_signal: RTL

//  Pedestrian crossing controller downstream of the traffic light FSM; consumes its
//  red/yellow/green outputs. Latches push-button requests and grants WALK only at the

---
 rtl/ped_walk_signal.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ped_walk_signal.sv
// ped_walk_signal
//   Pedestrian crossing controller. It sits downstream of the vehicle traffic
//   light FSM and reads that FSM's red/yellow/green outputs.
//   - A push-button request is latched and then granted as WALK, but only at
//     the start of a red phase.
//   - After WALK comes a flashing DON'T-WALK clearance interval.
//   - If red ends early, the controller drops to steady DON'T-WALK.
//   - It locks out on any illegal light pattern.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | steady DON'T-WALK, latching requests, waiting for a red rise
//   WALK  | WALK lamp on, counting down WALK_TICKS
//   FLASH | flashing DON'T-WALK clearance, counting down FLASH_TICKS
//   HOLD  | steady DON'T-WALK until the current red phase ends
//   FAULT | illegal light pattern seen; locked until reset
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   tick       one-cycle timebase strobe
//   button     pedestrian push-button (asynchronous level)
//   red/yellow/green  vehicle lights from the traffic light FSM
//   walk       WALK lamp
//   dont_walk  DON'T-WALK lamp (steady or flashing)
//   req_pend   request latched, awaiting grant
//   countdown  ticks remaining in WALK/FLASH, 0 otherwise
//   abort      one-cycle pulse when WALK/FLASH is cut short by red ending
//   fault      sticky illegal-light flag
module ped_walk_signal #(
    parameter int WALK_TICKS  = 10,
    parameter int FLASH_TICKS = 6,
    parameter int CW          = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          button,
    input  logic          red,
    input  logic          yellow,
    input  logic          green,
    output logic          walk,
    output logic          dont_walk,
    output logic          req_pend,
    output logic [CW-1:0] countdown,
    output logic          abort,
    output logic          fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WALK,
        S_FLASH,
        S_HOLD,
        S_FAULT
    } state_t;

    localparam logic [CW-1:0] WALK_LOAD  = CW'(WALK_TICKS);
    localparam logic [CW-1:0] FLASH_LOAD = CW'(FLASH_TICKS);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    state_t state;
    logic   btn_s1, btn_s2, btn_s3;
    logic   red_q;
    logic   btn_rise;
    logic   red_rise;
    logic   lights_ok;

    // btn_s3 only serves edge detection, so the request registers on the
    // third edge that samples the button high.
    assign btn_rise  = btn_s2 & ~btn_s3;
    assign red_rise  = red & ~red_q;
    assign lights_ok = ({red, yellow, green} == 3'b100) ||
                       ({red, yellow, green} == 3'b010) ||
                       ({red, yellow, green} == 3'b001);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            btn_s1    <= 1'b0;
            btn_s2    <= 1'b0;
            btn_s3    <= 1'b0;
            red_q     <= 1'b0;
            walk      <= 1'b0;
            dont_walk <= 1'b1;
            req_pend  <= 1'b0;
            countdown <= '0;
            abort     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            btn_s1 <= button;
            btn_s2 <= btn_s1;
            btn_s3 <= btn_s2;
            red_q  <= red;
            abort  <= 1'b0;

            if (!lights_ok) begin
                // Lockout overrides every other transition, from any state.
                state     <= S_FAULT;
                walk      <= 1'b0;
                dont_walk <= 1'b1;
                countdown <= '0;
                req_pend  <= 1'b0;
                fault     <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        walk      <= 1'b0;
                        dont_walk <= 1'b1;
                        countdown <= '0;
                        // Only a fresh red rise grants. A request latched
                        // during red therefore waits for the next red phase.
                        if (req_pend && red_rise) begin
                            state     <= S_WALK;
                            walk      <= 1'b1;
                            dont_walk <= 1'b0;
                            countdown <= WALK_LOAD;
                            req_pend  <= 1'b0;
                        end else if (btn_rise) begin
                            req_pend <= 1'b1;
                        end
                    end

                    S_WALK: begin
                        // Red ending early takes precedence over a
                        // coincident tick.
                        if (!red) begin
                            state     <= S_HOLD;
                            walk      <= 1'b0;
                            dont_walk <= 1'b1;
                            countdown <= '0;
                            abort     <= 1'b1;
                        end else if (tick) begin
                            if (countdown == CNT_ONE) begin
                                state     <= S_FLASH;
                                walk      <= 1'b0;
                                dont_walk <= 1'b1;
                                countdown <= FLASH_LOAD;
                            end else begin
                                countdown <= countdown - CNT_ONE;
                            end
                        end
                    end

                    S_FLASH: begin
                        if (!red) begin
                            state     <= S_HOLD;
                            walk      <= 1'b0;
                            dont_walk <= 1'b1;
                            countdown <= '0;
                            abort     <= 1'b1;
                        end else if (tick) begin
                            if (countdown == CNT_ONE) begin
                                state     <= S_HOLD;
                                dont_walk <= 1'b1;
                                countdown <= '0;
                            end else begin
                                countdown <= countdown - CNT_ONE;
                                dont_walk <= ~dont_walk;
                            end
                        end
                    end

                    S_HOLD: begin
                        walk      <= 1'b0;
                        dont_walk <= 1'b1;
                        countdown <= '0;
                        if (btn_rise) begin
                            req_pend <= 1'b1;
                        end
                        if (!red) begin
                            state <= S_IDLE;
                        end
                    end

                    S_FAULT: begin
                        walk      <= 1'b0;
                        dont_walk <= 1'b1;
                        countdown <= '0;
                        fault     <= 1'b1;
                    end

                    default: begin
                        state <= S_FAULT;
                    end
                endcase
            end
        end
    end

endmodule
